// File: rtl/rice_encoder_packer_pkg.sv
// Shared Rice coding constants, FSM state type and code-length helper.
// The decoder imports this same package, so the escape rule and bit order stay identical on both sides.
package rice_pkg;
    localparam int DATA_W = 16;
    localparam int K_W    = 4;
    localparam int ESC_Q  = 32;
    localparam int WORD_W = 64;
    localparam int LEN_W  = 7;

    typedef enum logic {
        RUN  = 1'b0,
        TAIL = 1'b1
    } state_e;

    // Escape codes are ESC_Q ones plus the raw sample and have no terminator.
    function automatic logic [LEN_W-1:0] code_len(input logic [DATA_W-1:0] q,
                                                  input logic [K_W-1:0]    k);
        if (q >= DATA_W'(ESC_Q))
            return LEN_W'(ESC_Q + DATA_W);
        else
            return LEN_W'(int'(q) + int'(k) + 1);
    endfunction
endpackage

// File: rtl/rice_encoder_packer_codeword_gen.sv
// Combinational Rice codeword former: left-aligned 64-bit code plus its length.
module rice_codeword_gen
    import rice_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    input  logic [K_W-1:0]    k,
    output logic [WORD_W-1:0] code,
    output logic [LEN_W-1:0]  len
);
    logic [K_W-1:0]    k_eff;
    logic [DATA_W-1:0] q;
    logic [DATA_W-1:0] r_mask;
    logic [DATA_W-1:0] r;
    logic [WORD_W-1:0] ones;

    always_comb begin
        k_eff = k;
        if (int'(k) > DATA_W - 1)
            k_eff = K_W'(DATA_W - 1);
        q      = data >> k_eff;
        r_mask = (DATA_W'(1) << k_eff) - DATA_W'(1);
        r      = data & r_mask;
        len    = code_len(q, k_eff);
        ones   = {WORD_W{1'b1}};
        if (q >= DATA_W'(ESC_Q)) begin
            code = ~(ones >> ESC_Q)
                 | ({{(WORD_W-DATA_W){1'b0}}, data} << (WORD_W - ESC_Q - DATA_W));
        end else begin
            // Unary run of q ones; the zero terminator is the gap left before r.
            code = ~(ones >> q)
                 | ({{(WORD_W-DATA_W){1'b0}}, r} << (WORD_W - int'(len)));
        end
    end
endmodule

// File: rtl/rice_encoder_packer.sv
// Rice encoder with MSB-first 64-bit packer, RUN/TAIL flush FSM and one registered output word.
module rice_encoder_packer
    import rice_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [K_W-1:0]    in_k,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_last
);
    logic [WORD_W-1:0]   acc_q, acc_d;
    logic [LEN_W-1:0]    fill_q, fill_d;
    state_e              state_q, state_d;
    logic                out_valid_q, out_valid_d;
    logic [WORD_W-1:0]   out_data_q, out_data_d;
    logic                out_last_q, out_last_d;

    logic [WORD_W-1:0]   code;
    logic [LEN_W-1:0]    len;
    logic [2*WORD_W-1:0] window;
    logic [LEN_W-1:0]    sum;
    logic                accept;

    rice_codeword_gen u_gen (
        .data (in_data),
        .k    (in_k),
        .code (code),
        .len  (len)
    );

    assign in_ready  = (state_q == RUN) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    // fill <= 63 and len <= 48, so the sum never exceeds 111 and fits LEN_W bits.
    assign sum       = fill_q + len;

    always_comb begin
        acc_d       = acc_q;
        fill_d      = fill_q;
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        window      = {acc_q, {WORD_W{1'b0}}} | ({code, {WORD_W{1'b0}}} >> fill_q);

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        case (state_q)
            RUN: begin
                if (accept) begin
                    if (sum < LEN_W'(WORD_W) && !in_last) begin
                        acc_d  = window[2*WORD_W-1:WORD_W];
                        fill_d = sum;
                    end else begin
                        out_valid_d = 1'b1;
                        out_data_d  = window[2*WORD_W-1:WORD_W];
                        out_last_d  = in_last && (sum <= LEN_W'(WORD_W));
                        acc_d       = window[WORD_W-1:0];
                        fill_d      = sum - LEN_W'(WORD_W);
                        if (in_last) begin
                            if (sum > LEN_W'(WORD_W)) begin
                                state_d = TAIL;
                            end else begin
                                acc_d  = '0;
                                fill_d = '0;
                            end
                        end
                    end
                end
            end
            TAIL: begin
                // Remainder is already zero-padded below fill in acc.
                if (!out_valid_q || out_ready) begin
                    out_valid_d = 1'b1;
                    out_data_d  = acc_q;
                    out_last_d  = 1'b1;
                    acc_d       = '0;
                    fill_d      = '0;
                    state_d     = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            fill_q      <= '0;
            state_q     <= RUN;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            fill_q      <= fill_d;
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end
endmodule
